// File: rtl/areg_wq_pkg.sv
// Shared types and helpers for the accumulating register file write queue.
package areg_pkg;

   // Register file word width.
   localparam int unsigned BITNESS = 16;

   typedef logic [BITNESS-1:0] word_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SET = 1'b1;

   typedef struct packed {
      logic        op;
      logic [3:0]  addr;
      word_t       val;
   } areg_req_t;

   // A write to entry a<8 also lands on a+8, so a reader of ra>=8 is
   // affected by writes to ra and to ra-8. Writes to a>=8 never touch
   // the low half.
   function automatic logic mirror_hit(input logic [3:0] a, input logic [3:0] ra);
      return (a == ra) || (ra[3] && (a == {1'b0, ra[2:0]}));
   endfunction

endpackage

// File: rtl/areg_req_fifo.sv
// Synchronous request FIFO with flush and an entry-valid scan vector.
module areg_req_fifo
   import areg_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  areg_req_t          din,
   input  logic               pop,
   input  logic               flush,
   output areg_req_t          dout,
   output logic               full,
   output logic               empty,
   output logic [CNTW-1:0]    count,
   output logic [DEPTH-1:0]   ent_valid,
   output logic [4*DEPTH-1:0] ent_addr
);

   localparam int unsigned AW = CNTW - 1;

   logic [CNTW-1:0] wr_ptr;
   logic [CNTW-1:0] rd_ptr;
   areg_req_t       mem [DEPTH];
   logic            do_push;
   logic            do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == CNTW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush wins over any push or pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write at the tail.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Slot g holds a live entry when its distance from the head is below
   // the occupancy; the subtraction wraps in the index width.
   for (genvar g = 0; g < DEPTH; g++) begin : g_scan
      logic [AW-1:0] off;
      assign off              = AW'(g) - rd_ptr[AW-1:0];
      assign ent_valid[g]     = ({1'b0, off} < count);
      assign ent_addr[4*g +: 4] = mem[g].addr;
   end

endmodule

// File: rtl/areg_wq.sv
// Write-request queue and issue stage for the accumulating register file.
module areg_wq
   import areg_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_set,
   input  logic [3:0]         in_addr,
   input  logic [BITNESS-1:0] in_val,
   input  logic               issue_en,
   input  logic               flush,
   output logic               w,
   output logic               y,
   output logic [3:0]         wa,
   output logic [BITNESS-1:0] wval,
   input  logic [3:0]         ra,
   output logic               ra_pend,
   output logic [CNTW-1:0]    count
);

   areg_req_t          req;
   areg_req_t          head;
   logic               full;
   logic               empty;
   logic               pop;
   logic [DEPTH-1:0]   ent_valid;
   logic [4*DEPTH-1:0] ent_addr;
   logic [DEPTH-1:0]   ent_hit;

   assign req      = '{op: in_set, addr: in_addr, val: in_val};
   assign in_ready = !full;
   assign pop      = !empty && issue_en && !flush;

   areg_req_fifo #(
      .DEPTH (DEPTH),
      .CNTW  (CNTW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid && in_ready),
      .din       (req),
      .pop       (pop),
      .flush     (flush),
      .dout      (head),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr)
   );

   // Issue registers: strobe every edge, payload held between issues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w    <= 1'b0;
         y    <= 1'b0;
         wa   <= '0;
         wval <= '0;
      end else begin
         w <= pop;
         if (pop) begin
            y    <= head.op;
            wa   <= head.addr;
            wval <= head.val;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      assign ent_hit[g] = ent_valid[g] && mirror_hit(ent_addr[4*g +: 4], ra);
   end

   // Hazard: any queued entry or the write currently on the port.
   always_comb begin
      ra_pend = (w && mirror_hit(wa, ra)) || (|ent_hit);
   end

endmodule

// File: tb/tb_areg_wq.sv
// Self-checking bench for areg_wq with a scoreboard of expected writes.
module tb_areg_wq;
   import areg_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNTW  = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               in_set = 1'b0;
   logic [3:0]         in_addr = '0;
   logic [BITNESS-1:0] in_val = '0;
   logic               issue_en = 1'b0;
   logic               flush = 1'b0;
   logic               w;
   logic               y;
   logic [3:0]         wa;
   logic [BITNESS-1:0] wval;
   logic [3:0]         ra = '0;
   logic               ra_pend;
   logic [CNTW-1:0]    count;

   int errors = 0;
   int checks = 0;

   // Requests accepted but not yet issued, in order.
   areg_req_t          sbq[$];
   logic               exp_w = 1'b0;
   logic               exp_y = 1'b0;
   logic [3:0]         exp_wa = '0;
   logic [BITNESS-1:0] exp_wval = '0;

   areg_wq #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_set   (in_set),
      .in_addr  (in_addr),
      .in_val   (in_val),
      .issue_en (issue_en),
      .flush    (flush),
      .w        (w),
      .y        (y),
      .wa       (wa),
      .wval     (wval),
      .ra       (ra),
      .ra_pend  (ra_pend),
      .count    (count)
   );

   always #5 clk = ~clk;

   function automatic logic model_pend(input logic [3:0] r);
      logic hit;
      hit = 1'b0;
      if (exp_w && (exp_wa == r || (r >= 4'd8 && exp_wa + 4'd8 == r))) hit = 1'b1;
      foreach (sbq[i]) begin
         if (sbq[i].addr == r || (r >= 4'd8 && sbq[i].addr + 4'd8 == r)) hit = 1'b1;
      end
      return hit;
   endfunction

   always @(negedge rst_n) begin
      sbq.delete();
      exp_w    = 1'b0;
      exp_y    = 1'b0;
      exp_wa   = '0;
      exp_wval = '0;
   end

   // Scoreboard: push accepted requests, pop on issue, compare after the edge.
   always @(posedge clk) begin
      areg_req_t req;
      areg_req_t hd;
      logic acc;
      logic iss;
      if (rst_n === 1'b1) begin
         acc = in_valid && (sbq.size() < DEPTH) && !flush;
         iss = (sbq.size() != 0) && issue_en && !flush;
         req = {in_set, in_addr, in_val};
         if (iss) begin
            hd       = sbq.pop_front();
            exp_w    = 1'b1;
            exp_y    = hd.op;
            exp_wa   = hd.addr;
            exp_wval = hd.val;
         end else begin
            exp_w = 1'b0;
         end
         if (flush) sbq.delete();
         if (acc) sbq.push_back(req);
         #1;
         if (rst_n === 1'b1) begin
            checks++;
            if (w !== exp_w) begin
               errors++;
               $display("FAIL sb_w: got %b expected %b at %0t", w, exp_w, $time);
            end
            checks++;
            if (y !== exp_y) begin
               errors++;
               $display("FAIL sb_y: got %b expected %b at %0t", y, exp_y, $time);
            end
            checks++;
            if (wa !== exp_wa) begin
               errors++;
               $display("FAIL sb_wa: got %0d expected %0d at %0t", wa, exp_wa, $time);
            end
            checks++;
            if (wval !== exp_wval) begin
               errors++;
               $display("FAIL sb_wval: got %h expected %h at %0t", wval, exp_wval, $time);
            end
            checks++;
            if (count !== CNTW'(sbq.size())) begin
               errors++;
               $display("FAIL sb_count: got %0d expected %0d at %0t", count, sbq.size(), $time);
            end
            checks++;
            if (ra_pend !== model_pend(ra)) begin
               errors++;
               $display("FAIL sb_ra_pend: got %b expected %b ra=%0d at %0t", ra_pend, model_pend(ra), ra, $time);
            end
         end
      end
   end

   task automatic drive_req(input logic s, input logic [3:0] a, input logic [BITNESS-1:0] v);
      in_valid = 1'b1;
      in_set   = s;
      in_addr  = a;
      in_val   = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (w !== 1'b0 || y !== 1'b0 || wa !== 4'd0 || wval !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got w=%b y=%b wa=%0d wval=%h expected all zero", w, y, wa, wval);
      end
      checks++;
      if (count !== 3'd0 || in_ready !== 1'b1 || ra_pend !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: got count=%0d in_ready=%b ra_pend=%b expected 0/1/0", count, in_ready, ra_pend);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      issue_en = 1'b1;
      drive_req(1'b1, 4'd3, 16'h002A);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (w !== 1'b0 || count !== 3'd1) begin
         errors++;
         $display("FAIL single_nobypass: got w=%b count=%0d expected w=0 count=1", w, count);
      end
      @(negedge clk);
      checks++;
      if (w !== 1'b1 || y !== 1'b1 || wa !== 4'd3 || wval !== 16'h002A || count !== 3'd0) begin
         errors++;
         $display("FAIL single_issue: got w=%b y=%b wa=%0d wval=%h count=%0d expected 1 1 3 002a 0", w, y, wa, wval, count);
      end
      @(negedge clk);
      checks++;
      if (w !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL single_after: got w=%b count=%0d expected 0 0", w, count);
      end
      issue_en = 1'b0;
   endtask

   task automatic test_fill();
      issue_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_req(i[0], 4'(i), BITNESS'(32'h100 + i));
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: got count=%0d in_ready=%b expected 4 0", count, in_ready);
      end
      drive_req(1'b1, 4'd9, 16'h0BAD);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL fill_reject: got count=%0d expected 4", count);
      end
      issue_en = 1'b1;
      @(negedge clk);
      checks++;
      if (w !== 1'b1 || wa !== 4'd0 || in_ready !== 1'b1 || count !== 3'd3) begin
         errors++;
         $display("FAIL fill_first_pop: got w=%b wa=%0d in_ready=%b count=%0d expected 1 0 1 3", w, wa, in_ready, count);
      end
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (w !== 1'b1 || wa !== 4'(i)) begin
            errors++;
            $display("FAIL fill_drain: got w=%b wa=%0d expected 1 %0d", w, wa, i);
         end
      end
      @(negedge clk);
      checks++;
      if (w !== 1'b0) begin
         errors++;
         $display("FAIL fill_idle: got w=%b expected 0", w);
      end
      issue_en = 1'b0;
   endtask

   task automatic test_mirror();
      issue_en = 1'b0;
      drive_req(OP_ADD, 4'd5, 16'h0001);
      @(negedge clk);
      in_valid = 1'b0;
      ra = 4'd13; #1;
      checks++;
      if (ra_pend !== 1'b1) begin
         errors++;
         $display("FAIL mirror_ra13: got %b expected 1", ra_pend);
      end
      ra = 4'd5; #1;
      checks++;
      if (ra_pend !== 1'b1) begin
         errors++;
         $display("FAIL mirror_ra5: got %b expected 1", ra_pend);
      end
      ra = 4'd4; #1;
      checks++;
      if (ra_pend !== 1'b0) begin
         errors++;
         $display("FAIL mirror_ra4: got %b expected 0", ra_pend);
      end
      @(negedge clk);
      drive_req(OP_SET, 4'd12, 16'h0007);
      @(negedge clk);
      in_valid = 1'b0;
      ra = 4'd4; #1;
      checks++;
      if (ra_pend !== 1'b0) begin
         errors++;
         $display("FAIL mirror_high_no_low: got %b expected 0", ra_pend);
      end
      ra = 4'd12; #1;
      checks++;
      if (ra_pend !== 1'b1) begin
         errors++;
         $display("FAIL mirror_ra12: got %b expected 1", ra_pend);
      end
      issue_en = 1'b1;
      repeat (3) @(negedge clk);
      issue_en = 1'b0;
      ra = 4'd13; #1;
      checks++;
      if (ra_pend !== 1'b0) begin
         errors++;
         $display("FAIL mirror_drained: got %b expected 0", ra_pend);
      end
   endtask

   task automatic test_inflight();
      issue_en = 1'b1;
      ra = 4'd15;
      drive_req(OP_ADD, 4'd7, 16'h0077);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (ra_pend !== 1'b1 || w !== 1'b0) begin
         errors++;
         $display("FAIL inflight_queued: got ra_pend=%b w=%b expected 1 0", ra_pend, w);
      end
      @(negedge clk); #1;
      checks++;
      if (ra_pend !== 1'b1 || w !== 1'b1) begin
         errors++;
         $display("FAIL inflight_on_port: got ra_pend=%b w=%b expected 1 1", ra_pend, w);
      end
      @(negedge clk); #1;
      checks++;
      if (ra_pend !== 1'b0 || w !== 1'b0) begin
         errors++;
         $display("FAIL inflight_done: got ra_pend=%b w=%b expected 0 0", ra_pend, w);
      end
      issue_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] addrs [6];
      logic       sets  [6];
      addrs = '{4'd8, 4'd10, 4'd10, 4'd3, 4'd15, 4'd0};
      sets  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      issue_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_req(sets[i], addrs[i], BITNESS'(i * 3 + 1));
         @(negedge clk);
         checks++;
         if (count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 1 at step %0d", count, i);
         end
         if (i > 0) begin
            checks++;
            if (w !== 1'b1 || wa !== addrs[i-1] || wval !== BITNESS'((i - 1) * 3 + 1)) begin
               errors++;
               $display("FAIL b2b_issue: got w=%b wa=%0d wval=%h expected 1 %0d at step %0d", w, wa, wval, addrs[i-1], i);
            end
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (w !== 1'b1 || wa !== 4'd0 || count !== 3'd0) begin
         errors++;
         $display("FAIL b2b_last: got w=%b wa=%0d count=%0d expected 1 0 0", w, wa, count);
      end
      @(negedge clk);
      issue_en = 1'b0;
   endtask

   task automatic test_flush();
      issue_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive_req(OP_ADD, 4'(i), BITNESS'(32'h40 + i));
         @(negedge clk);
      end
      in_valid = 1'b0;
      issue_en = 1'b1;
      @(negedge clk);
      checks++;
      if (w !== 1'b1 || wa !== 4'd1 || count !== 3'd3) begin
         errors++;
         $display("FAIL flush_pre: got w=%b wa=%0d count=%0d expected 1 1 3", w, wa, count);
      end
      flush = 1'b1;
      drive_req(OP_SET, 4'd9, 16'h0099);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got %b expected 1", in_ready);
      end
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (w !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL flush_post: got w=%b count=%0d expected 0 0", w, count);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (w !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet: got w=%b expected 0", w);
         end
      end
      issue_en = 1'b0;
   endtask

   task automatic test_async_reset();
      issue_en = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         drive_req(OP_SET, 4'(i), BITNESS'(32'h20 + i));
         @(negedge clk);
      end
      in_valid = 1'b0;
      issue_en = 1'b1;
      ra = 4'd2;
      @(negedge clk);
      checks++;
      if (w !== 1'b1 || wa !== 4'd2) begin
         errors++;
         $display("FAIL areset_pre: got w=%b wa=%0d expected 1 2", w, wa);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (w !== 1'b0 || count !== 3'd0 || ra_pend !== 1'b0 || in_ready !== 1'b1 || wa !== 4'd0) begin
         errors++;
         $display("FAIL areset_now: got w=%b count=%0d ra_pend=%b in_ready=%b wa=%0d expected 0 0 0 1 0", w, count, ra_pend, in_ready, wa);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_req(OP_SET, 4'd6, 16'h0066);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (w !== 1'b1 || wa !== 4'd6 || wval !== 16'h0066 || y !== 1'b1) begin
         errors++;
         $display("FAIL areset_resume: got w=%b wa=%0d wval=%h y=%b expected 1 6 0066 1", w, wa, wval, y);
      end
      @(negedge clk);
      checks++;
      if (w !== 1'b0) begin
         errors++;
         $display("FAIL areset_idle: got w=%b expected 0", w);
      end
      issue_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_mirror();
      test_inflight();
      test_back_to_back();
      test_flush();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/areg_wq.md
Name: areg_wq

Overview:
- Write-request queue and issue stage sitting directly upstream of the 16-entry accumulating register file.
- Accepts register-update requests (set or add) on a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one registered write per cycle onto the register file's write port (w, y, wa, wval).
- Reports a read-after-write hazard for the register file read address, accounting for the low-to-high mirroring: a write to entry k<8 also updates entry k+8.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2.
CNTW, $clog2(DEPTH)+1, width of occupancy count.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request present.
in_ready  out  1  queue can accept a request.
in_set  in  1  1 = overwrite, 0 = add to current value (drives y).
in_addr  in  4  target register.
in_val  in  `WORD  write operand (width `BITNESS from spec.sv).
issue_en  in  1  permits issuing the FIFO head this cycle.
flush  in  1  synchronous discard of all queued, not-yet-issued requests.
w  out  1  register-file write strobe.
y  out  1  register-file set/add select.
wa  out  4  register-file write address.
wval  out  `WORD  register-file write data.
ra  in  4  register-file read address, for hazard checking.
ra_pend  out  1  a queued or in-flight write affects ra.
count  out  CNTW  number of queued entries (excludes in-flight).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count go to 0; in_ready=1.
  - w=0, y=0, wa=0, wval=0, ra_pend=0.
  - Reset mid-operation discards all queued and in-flight writes; w drops immediately.
- Enqueue:
  - On a rising edge where in_valid && in_ready, {in_set, in_addr, in_val} is written at the tail.
  - in_ready = !full, computed from the current count only. A pop in the same cycle does not free a slot for a same-cycle push.
- Issue (output registers, updated every edge):
  - If !empty && issue_en && !flush: outputs load the head, w=1, and the head pops.
  - Otherwise w=0. y, wa and wval hold their last values.
  - w is a single-cycle pulse per entry. Back-to-back issues give continuous w=1 with new wa/wval each cycle.
- Latency: a request accepted at edge N into an empty queue shows w=1 from edge N+1. The register file commits it at edge N+2. There is no bypass from input to outputs.
- Simultaneous push and pop when neither full nor empty: both occur, and count is unchanged.
- Ordering: strict FIFO. Two adds to the same address are both issued in order. No coalescing.
- flush:
  - At the edge, pointers and count are set to 0 and no issue occurs (w=0 next cycle).
  - A write already on the outputs (w=1 this cycle) still completes in the register file.
  - An in_valid in the same cycle as flush is dropped; in_ready is still !full.
- ra_pend is combinational. It is 1 if any valid FIFO entry, or the current output when w=1, has address a where:
  - a == ra, or
  - ra >= 8 and a == ra-8 (the mirrored write).
  - Writes to a >= 8 never flag ra < 8.
- Wrap-around: pointers are CNTW bits wide. The low bits index the FIFO, and the MSB distinguishes full from empty.

Decomposition:
- Package areg_pkg:
  - OP_ADD=1'b0, OP_SET=1'b1.
  - Packed struct areg_req_t {op, addr[3:0], val `WORD}.
  - Function mirror_hit(a, ra) implementing the hazard match rule.
- Sub-module areg_req_fifo: parameterised synchronous FIFO of areg_req_t with push, pop, flush, full, empty and count, plus a flattened entry-valid vector for the hazard scan.
- areg_wq holds the issue registers and the hazard logic.

Test Plan:
- Reset then single request: push {set=1, addr=3, val=0x2A} with issue_en=1 -> w=1, y=1, wa=3, wval=0x2A exactly one cycle later; after that, w=0 and count=0.
- Fill: issue_en=0, push 4 requests (addr 0..3) -> in_ready=0 with count=4; a 5th in_valid is not accepted. Raise issue_en -> w=1 for 4 consecutive cycles with wa 0,1,2,3 in order; in_ready returns 1 the cycle after the first pop.
- Mirror hazard: queue {add, addr=5, val=1}, ra=13 -> ra_pend=1. ra=5 -> 1. ra=4 -> 0. Queue {set, addr=12}, ra=4 -> 0.
- In-flight hazard: single entry addr=7 issued; ra=15 -> ra_pend=1 while w=1, then 0 the following cycle.
- flush: 3 entries queued and the head issuing this cycle; assert flush -> the in-flight write completes, w=0 next cycle, count=0, no further writes.
- Async reset mid-burst: drop rst_n between edges while w=1 -> w, count and ra_pend go to 0 immediately; after release, the first new push issues normally.
